spi_dev_framer: RTL and testbench
=================================

Name: spi_dev_framer

Overview:
- Sits between the SPI device shift-register core and the SPI-to-Wishbone bridge, in the system clock domain.
- Turns the raw SPI byte stream and chip-select level into the protocol-wrapper write interface consumed by the bridge: pw_wdata, pw_wcmd, pw_wstb, pw_end.
- Filters frames by command ID so that only matching frames reach the bridge.
- Buffers response bytes from the bridge in a small FIFO and presents them to the core for MISO shifting.

Parameters:
- CMD_ID, 8'hf0: command byte value that selects this port.
- CMD_MASK, 8'hff: bits of the command byte compared against CMD_ID.
- RFIFO_DEPTH, 4: response FIFO depth in bytes; power of two, 2 to 16.
- MISO_FILL, 8'h00: byte presented on MISO while the response FIFO is empty.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- usr_cs  in  1  chip select, active high, already synchronized to clk
- usr_mosi_data  in  8  received byte
- usr_mosi_stb  in  1  one-cycle strobe, usr_mosi_data valid
- usr_miso_data  out  8  next byte to shift out
- usr_miso_ack  in  1  one-cycle pulse, core has latched usr_miso_data
- pw_wdata  out  8  byte to bridge
- pw_wcmd  out  1  qualifies pw_wstb: byte is the frame command byte
- pw_wstb  out  1  one-cycle write strobe
- pw_end  out  1  one-cycle end-of-frame pulse
- pw_rdata  in  8  response byte from bridge
- pw_rstb  in  1  push pw_rdata into response FIFO
- stat_frames  out  16  accepted-frame counter (optional feature)
- stat_ovfl  out  1  sticky response-overflow flag (optional feature)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pw_wstb, pw_end, pw_wcmd = 0; pw_wdata = 8'h00.
  - FIFO empty; usr_miso_data = MISO_FILL; FSM in IDLE; stats cleared.
- All pw_* outputs are registered.
- Latency: pw_wstb is asserted exactly 1 clk after the usr_mosi_stb that caused it.
- FSM states and transitions:
  - IDLE to CMD: usr_cs rising edge. The response FIFO is flushed on this edge.
  - CMD, first strobe, (data & CMD_MASK) == (CMD_ID & CMD_MASK): forward the byte with pw_wcmd=1 and go to ACTIVE.
  - CMD, first strobe, no match: go to IGNORE; nothing is forwarded.
  - ACTIVE: every strobe is forwarded with pw_wcmd=0.
  - IGNORE: strobes are discarded.
  - ACTIVE or IGNORE, usr_cs low: go to IDLE.
  - CMD, usr_cs low (frame with no bytes): go to IDLE; no pw_end is issued.
- pw_end:
  - One-cycle pulse on the cycle after usr_cs is seen low in ACTIVE only; never issued for IGNORE.
  - If usr_mosi_stb and the usr_cs fall arrive in the same cycle, the byte is forwarded first (pw_wstb at T+1) and pw_end follows at T+2. pw_wstb and pw_end are never high together.
- Back-to-back frames: a usr_cs rise on the cycle after pw_end is legal and is handled normally.
- Response FIFO:
  - A pw_rstb push is accepted in any state.
  - Push while full: the byte is dropped, FIFO contents are unchanged, and stat_ovfl is set.
  - usr_miso_data is the head entry when non-empty, else MISO_FILL; it is combinational from the FIFO storage and level.
  - usr_miso_ack pops when non-empty; an ack on an empty FIFO is ignored.
  - Simultaneous push and pop: both take effect, and the level is unchanged.
  - When full, a simultaneous push and pop is accepted (no overflow).
  - Pointers wrap modulo RFIFO_DEPTH; level is tracked in log2(RFIFO_DEPTH)+1 bits.
- Flush on usr_cs rise has priority over a same-cycle push and pop.
- Reset mid-frame returns to IDLE immediately with no pw_end. A frame already in progress is then ignored until the next usr_cs rise.

Optional Feature:
- Macro: SPI_DEV_FRAMER_STATS_EN.
- Defined:
  - stat_frames increments on every pw_end and wraps at 16'hffff to 0.
  - stat_ovfl is set on any dropped push and cleared only by rst.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
- CS high; bytes f0,a1,12,34 with 3-clk spacing; CS low. Required response:
  - pw_wstb four times, each 1 clk after its strobe.
  - pw_wcmd=1 only for f0.
  - A single pw_end after the last byte.
- CS high; bytes 0f,55; CS low. Required response: no pw_wstb and no pw_end (command mismatch). Repeat with CMD_MASK=8'hf0 and command f7: accepted.
- Last byte strobe in the same cycle as CS falling. Required response: pw_wstb at T+1, pw_end at T+2, never overlapping.
- Push 5 bytes 11..15 with depth 4. Required response:
  - MISO reads 11,12,13,14, then MISO_FILL.
  - stat_ovfl=1 (STATS_EN build).
- FIFO full, pw_rstb and usr_miso_ack in the same cycle. Required response: level stays 4, head advances, no overflow flag.
- rst asserted mid-frame after 2 forwarded bytes. Required response:
  - Outputs return to reset values and no pw_end is issued.
  - Later bytes of that frame are ignored until the next CS rise.

Source files
------------

// File: rtl/spi_dev_framer.sv
// spi_dev_framer: frames the SPI device byte stream into protocol-wrapper writes
// for the Wishbone bridge. Only frames whose command byte matches CMD_ID/CMD_MASK
// are forwarded. Response bytes from the bridge wait in a small FIFO until the
// core shifts them out on MISO.
// Build option: define SPI_DEV_FRAMER_STATS_EN to get stat_frames / stat_ovfl;
// without it both outputs are tied to zero.
module spi_dev_framer #(
  parameter logic [7:0]  CMD_ID      = 8'hf0,
  parameter logic [7:0]  CMD_MASK    = 8'hff,
  parameter int unsigned RFIFO_DEPTH = 4,
  parameter logic [7:0]  MISO_FILL   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        usr_cs,
  input  logic [7:0]  usr_mosi_data,
  input  logic        usr_mosi_stb,
  output logic [7:0]  usr_miso_data,
  input  logic        usr_miso_ack,
  output logic [7:0]  pw_wdata,
  output logic        pw_wcmd,
  output logic        pw_wstb,
  output logic        pw_end,
  input  logic [7:0]  pw_rdata,
  input  logic        pw_rstb,
  output logic [15:0] stat_frames,
  output logic        stat_ovfl
);

  localparam int unsigned AW = $clog2(RFIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, CMD, ACTIVE, IGNORE} state_t;

  state_t state, state_nxt;
  logic   cs_q;
  logic   cs_rise;
  logic   cmd_match;
  logic   wstb_nxt, wcmd_nxt, end_nxt, flush;

  assign cs_rise   = usr_cs & ~cs_q;
  assign cmd_match = ((usr_mosi_data & CMD_MASK) == (CMD_ID & CMD_MASK));

  // State register; cs_q resets high so a frame already in progress is not taken as a new rise
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cs_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      cs_q  <= usr_cs;
    end
  end

  // Next-state logic; a strobe in ACTIVE is served before a same-cycle CS fall
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_rise) state_nxt = CMD;
      CMD: begin
        if (usr_mosi_stb)  state_nxt = cmd_match ? ACTIVE : IGNORE;
        else if (!usr_cs)  state_nxt = IDLE;
      end
      ACTIVE:  if (!usr_mosi_stb && !usr_cs) state_nxt = IDLE;
      IGNORE:  if (!usr_cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered pw_* outputs and the FIFO flush
  always_comb begin
    wstb_nxt = 1'b0;
    wcmd_nxt = 1'b0;
    end_nxt  = 1'b0;
    flush    = 1'b0;
    case (state)
      IDLE: flush = cs_rise;
      CMD: begin
        if (usr_mosi_stb && cmd_match) begin
          wstb_nxt = 1'b1;
          wcmd_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (usr_mosi_stb) wstb_nxt = 1'b1;
        else if (!usr_cs) end_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered bridge write interface; pw_wdata holds the last forwarded byte
  always_ff @(posedge clk) begin
    if (rst) begin
      pw_wstb  <= 1'b0;
      pw_wcmd  <= 1'b0;
      pw_end   <= 1'b0;
      pw_wdata <= 8'h00;
    end else begin
      pw_wstb <= wstb_nxt;
      pw_wcmd <= wcmd_nxt;
      pw_end  <= end_nxt;
      if (wstb_nxt) pw_wdata <= usr_mosi_data;
    end
  end

  logic [7:0]    mem [RFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          empty, full, push, pop;

  assign empty = (level == '0);
  assign full  = (level == LW'(RFIFO_DEPTH));
  assign pop   = usr_miso_ack & ~empty;
  assign push  = pw_rstb & (~full | pop);

  // Response FIFO pointers and level; flush wins over a same-cycle push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Response FIFO storage; a stale write during flush is never read back
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pw_rdata;
  end

  assign usr_miso_data = empty ? MISO_FILL : mem[rd_ptr];

`ifdef SPI_DEV_FRAMER_STATS_EN
  logic        drop;
  logic [15:0] frames_q;
  logic        ovfl_q;

  assign drop = pw_rstb & full & ~pop & ~flush;

  // Accepted-frame counter (counts with pw_end) and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= 16'h0000;
      ovfl_q   <= 1'b0;
    end else begin
      if (end_nxt) frames_q <= frames_q + 16'd1;
      if (drop)    ovfl_q   <= 1'b1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_ovfl   = ovfl_q;
`else
  assign stat_frames = 16'h0000;
  assign stat_ovfl   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dev_framer.sv
// tb_spi_dev_framer: randomized and directed stimulus for spi_dev_framer, checked
// against a frame-level reference model. Two instances share the inputs: one with
// the default command mask and one with CMD_MASK = 8'hf0.
module tb_spi_dev_framer;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  FILL  = 8'h00;
  localparam logic [7:0]  CID   = 8'hf0;

  logic        clk = 1'b0;
  logic        rst;
  logic        usr_cs, usr_mosi_stb, usr_miso_ack, pw_rstb;
  logic [7:0]  usr_mosi_data, pw_rdata;

  logic [7:0]  miso0, miso1, wdata0, wdata1;
  logic        wcmd0, wcmd1, wstb0, wstb1, pend0, pend1, ovfl0, ovfl1;
  logic [15:0] frames0, frames1;

  always #5 clk = ~clk;

  spi_dev_framer #(.CMD_ID(CID), .CMD_MASK(8'hff), .RFIFO_DEPTH(DEPTH), .MISO_FILL(FILL)) u_dut (
    .clk(clk), .rst(rst), .usr_cs(usr_cs), .usr_mosi_data(usr_mosi_data),
    .usr_mosi_stb(usr_mosi_stb), .usr_miso_data(miso0), .usr_miso_ack(usr_miso_ack),
    .pw_wdata(wdata0), .pw_wcmd(wcmd0), .pw_wstb(wstb0), .pw_end(pend0),
    .pw_rdata(pw_rdata), .pw_rstb(pw_rstb), .stat_frames(frames0), .stat_ovfl(ovfl0));

  spi_dev_framer #(.CMD_ID(CID), .CMD_MASK(8'hf0), .RFIFO_DEPTH(DEPTH), .MISO_FILL(FILL)) u_dut_m (
    .clk(clk), .rst(rst), .usr_cs(usr_cs), .usr_mosi_data(usr_mosi_data),
    .usr_mosi_stb(usr_mosi_stb), .usr_miso_data(miso1), .usr_miso_ack(usr_miso_ack),
    .pw_wdata(wdata1), .pw_wcmd(wcmd1), .pw_wstb(wstb1), .pw_end(pend1),
    .pw_rdata(pw_rdata), .pw_rstb(pw_rstb), .stat_frames(frames1), .stat_ovfl(ovfl1));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state: frame open/closed, per-instance command verdict, response queue
  bit          open_f;
  logic        cs_prev;
  bit          decided [2];
  bit          acc     [2];
  logic        exp_wstb [2];
  logic        exp_wcmd [2];
  logic        exp_end  [2];
  logic [7:0]  exp_wdata[2];
  logic [15:0] nframes  [2];
  logic        exp_ovfl;
  logic [7:0]  rq[$];
  logic [7:0]  fb[$];
  bit          rnd_fifo = 1'b0;
  bit          rnd_rst  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask_of(input int i);
    return (i == 0) ? 8'hff : 8'hf0;
  endfunction

  // One clock: apply inputs, advance the model, then compare at the falling edge
  task automatic cycle(input logic cs, input logic stb, input logic [7:0] d,
                       input logic rstb, input logic [7:0] rd, input logic ack);
    bit   rise;
    bit   popped;
    logic [7:0] exp_miso;
    usr_cs = cs; usr_mosi_stb = stb; usr_mosi_data = d;
    pw_rstb = rstb; pw_rdata = rd; usr_miso_ack = ack;

    rise = cs && !cs_prev && !open_f;
    for (int i = 0; i < 2; i++) begin
      exp_wstb[i] = 1'b0; exp_wcmd[i] = 1'b0; exp_end[i] = 1'b0;
    end
    if (rst) begin
      open_f = 1'b0;
      exp_ovfl = 1'b0;
      rq.delete();
      for (int i = 0; i < 2; i++) begin
        exp_wdata[i] = 8'h00; nframes[i] = 16'h0000;
      end
    end else if (rise) begin
      open_f = 1'b1;
      rq.delete();
      for (int i = 0; i < 2; i++) begin
        decided[i] = 1'b0; acc[i] = 1'b0;
      end
    end else begin
      if (open_f) begin
        for (int i = 0; i < 2; i++) begin
          if (stb) begin
            if (!decided[i]) begin
              decided[i]  = 1'b1;
              acc[i]      = ((d & mask_of(i)) == (CID & mask_of(i)));
              exp_wcmd[i] = acc[i];
            end
            if (acc[i]) begin
              exp_wstb[i] = 1'b1; exp_wdata[i] = d;
            end
          end else if (!cs && acc[i]) begin
            exp_end[i] = 1'b1;
            nframes[i] = nframes[i] + 16'd1;
          end
        end
        if (!stb && !cs) open_f = 1'b0;
      end
      popped = ack && (rq.size() > 0);
      if (popped) void'(rq.pop_front());
      if (rstb) begin
        if (rq.size() < DEPTH) rq.push_back(rd);
        else exp_ovfl = 1'b1;
      end
    end
    cs_prev = rst ? 1'b1 : cs;

    @(posedge clk);
    @(negedge clk);
    exp_miso = (rq.size() > 0) ? rq[0] : FILL;
    check("wstb0",  32'(wstb0),  32'(exp_wstb[0]));
    check("wcmd0",  32'(wcmd0),  32'(exp_wcmd[0]));
    check("wdata0", 32'(wdata0), 32'(exp_wdata[0]));
    check("end0",   32'(pend0),  32'(exp_end[0]));
    check("wstb1",  32'(wstb1),  32'(exp_wstb[1]));
    check("wcmd1",  32'(wcmd1),  32'(exp_wcmd[1]));
    check("wdata1", 32'(wdata1), 32'(exp_wdata[1]));
    check("end1",   32'(pend1),  32'(exp_end[1]));
    check("miso0",  32'(miso0),  32'(exp_miso));
    check("miso1",  32'(miso1),  32'(exp_miso));
`ifdef SPI_DEV_FRAMER_STATS_EN
    check("frames0", 32'(frames0), 32'(nframes[0]));
    check("frames1", 32'(frames1), 32'(nframes[1]));
    check("ovfl0",   32'(ovfl0),   32'(exp_ovfl));
    check("ovfl1",   32'(ovfl1),   32'(exp_ovfl));
`else
    check("frames0", 32'(frames0), 32'h0);
    check("ovfl0",   32'(ovfl0),   32'h0);
`endif
  endtask

  // Frame-stream cycle with optional random response traffic and random reset
  task automatic tick(input logic cs, input logic stb, input logic [7:0] d);
    logic rs, ak;
    logic [7:0] rd;
    rs  = rnd_fifo && ($urandom_range(0, 3) == 0);
    ak  = rnd_fifo && ($urandom_range(0, 2) == 0);
    rd  = 8'($urandom);
    rst = rnd_rst && ($urandom_range(0, 149) == 0);
    cycle(cs, stb, d, rs, rd, ak);
    rst = 1'b0;
  endtask

  // Send the bytes in fb as one frame; CS stays low long enough for the frame to close
  task automatic run_frame(input int gap, input bit at_fall, input int extra_low);
    int n;
    n = fb.size();
    tick(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < n; k++) begin
      repeat (gap) tick(1'b1, 1'b0, 8'h00);
      if (k == n - 1 && at_fall) tick(1'b0, 1'b1, fb[k]);
      else                       tick(1'b1, 1'b1, fb[k]);
    end
    tick(1'b0, 1'b0, 8'h00);
    repeat (extra_low) tick(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    usr_cs = 1'b0; usr_mosi_stb = 1'b0; usr_mosi_data = 8'h00;
    pw_rstb = 1'b0; pw_rdata = 8'h00; usr_miso_ack = 1'b0;
    cs_prev = 1'b1; open_f = 1'b0; exp_ovfl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      decided[i] = 1'b0; acc[i] = 1'b0; exp_wdata[i] = 8'h00; nframes[i] = 16'h0000;
    end

    rst = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Accepted frame with 3-clock byte spacing
    fb = '{8'hf0, 8'ha1, 8'h12, 8'h34};
    run_frame(3, 1'b0, 2);
    // Command mismatch on both instances, then f7 accepted only by the masked one
    fb = '{8'h0f, 8'h55};
    run_frame(1, 1'b0, 1);
    fb = '{8'hf7, 8'h55, 8'h66};
    run_frame(0, 1'b0, 1);
    // Last byte together with CS fall, followed by a back-to-back frame
    fb = '{8'hf0, 8'h77};
    run_frame(2, 1'b1, 0);
    fb = '{8'hf0, 8'h88};
    run_frame(0, 1'b0, 0);
    // Empty frame
    fb.delete();
    run_frame(0, 1'b0, 1);

    // Overfill the response FIFO, then drain past empty
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h11 + k), 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Full FIFO with simultaneous push and pop is not an overflow
    rst = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'ha0 + k), 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'hb0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Reset mid-frame after two forwarded bytes; the rest of that frame is ignored
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'hf0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'ha1, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'hf0, 1'b0, 8'h00, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Randomized frames with background response traffic and occasional resets
    rnd_fifo = 1'b1;
    rnd_rst  = 1'b1;
    for (int f = 0; f < 250; f++) begin
      int n;
      int sel;
      n   = $urandom_range(0, 5);
      sel = $urandom_range(0, 2);
      fb.delete();
      for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
      if (n > 0) begin
        if (sel == 0)      fb[0] = 8'hf0;
        else if (sel == 1) fb[0] = {4'hf, 4'($urandom)};
      end
      run_frame($urandom_range(0, 3), (n > 0) && ($urandom_range(0, 1) == 1),
                $urandom_range(0, 2));
    end
    rnd_fifo = 1'b0;
    rnd_rst  = 1'b0;
    repeat (6) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
